// File: rtl/iob_timer_pkg.sv
// iob_timer_pkg: register map, FSM encoding and default width for the timer bus master
package iob_timer_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_RESET = 0;
  localparam int REG_STOP = 1;
  localparam int REG_HIGH = 2;
  localparam int REG_LOW = 3;
  typedef enum logic [2:0] {IDLE, RST_REQ, STOP_REQ, GAP1, RD_HI, GAP2, RD_LO, DONE} state_t;
endpackage

// File: rtl/iob_timer_bus_xfer.sv
// iob_timer_bus_xfer: single valid/ready transaction with bounded wait
module iob_timer_bus_xfer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] go_addr,
  input  logic [DATA_W-1:0] go_wdata,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              ok,
  output logic              tmo
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign ok = m_valid & m_ready;
  assign tmo = m_valid & ~m_ready & last;
  // hold the request until acknowledged or the wait budget runs out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
      cnt <= '0;
    end else if (go) begin
      m_valid <= 1'b1;
      m_addr <= go_addr;
      m_wdata <= go_wdata;
      cnt <= '0;
    end else if (m_valid) begin
      m_valid <= ~(m_ready | last);
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/iob_timer_master.sv
// iob_timer_master: sequences soft-reset and capture/read commands to a timer responder
module iob_timer_master
  import iob_timer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W = 2,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sample,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [2*DATA_W-1:0] result,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready
);
  state_t state, state_d;
  logic go, ok, tmo;
  logic [ADDR_W-1:0] go_addr;
  logic [DATA_W-1:0] go_wdata, hi;
  assign busy = state != IDLE;
  assign done = state == DONE;
  iob_timer_bus_xfer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_xfer (
    .clk(clk), .rst_n(rst_n), .go(go), .go_addr(go_addr), .go_wdata(go_wdata), .m_ready(m_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .ok(ok), .tmo(tmo)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  // next state and transaction launch; a gap state precedes each read so ready can drop
  always_comb begin
    state_d = state;
    go = 1'b0;
    go_addr = ADDR_W'(REG_RESET);
    go_wdata = '0;
    case (state)
      IDLE: begin
        go = start | sample;
        state_d = start ? RST_REQ : sample ? STOP_REQ : IDLE;
        go_addr = start ? ADDR_W'(REG_RESET) : ADDR_W'(REG_STOP);
        go_wdata = start ? DATA_W'(1) : '0;
      end
      RST_REQ: state_d = (ok | tmo) ? DONE : RST_REQ;
      STOP_REQ: state_d = ok ? GAP1 : tmo ? DONE : STOP_REQ;
      GAP1: begin
        state_d = RD_HI;
        go = 1'b1;
        go_addr = ADDR_W'(REG_HIGH);
      end
      RD_HI: state_d = ok ? GAP2 : tmo ? DONE : RD_HI;
      GAP2: begin
        state_d = RD_LO;
        go = 1'b1;
        go_addr = ADDR_W'(REG_LOW);
      end
      RD_LO: state_d = (ok | tmo) ? DONE : RD_LO;
      default: state_d = IDLE;
    endcase
  end
  // capture read data, publish result only when both words arrived, track sticky timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      result <= '0;
      error <= 1'b0;
    end else begin
      if (state == RD_HI && ok) hi <= m_rdata;
      if (state == RD_LO && ok) result <= {hi, m_rdata};
      if (tmo) error <= 1'b1;
      else if (state == IDLE && (start | sample)) error <= 1'b0;
    end
  end
endmodule
